// File: rtl/mips_muldiv_pkg.sv
// Shared decode constants, state/op encodings and helpers for the MIPS multiply/divide unit.
package mips_muldiv_pkg;

    localparam logic [5:0] FUNCT_MFHI  = 6'h10;
    localparam logic [5:0] FUNCT_MTHI  = 6'h11;
    localparam logic [5:0] FUNCT_MFLO  = 6'h12;
    localparam logic [5:0] FUNCT_MTLO  = 6'h13;
    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_DIV   = 6'h1A;
    localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        FIX
    } state_t;

    typedef enum logic [3:0] {
        OP_NONE,
        OP_MULT,
        OP_MULTU,
        OP_DIV,
        OP_DIVU,
        OP_MFHI,
        OP_MFLO,
        OP_MTHI,
        OP_MTLO
    } op_t;

    function automatic int clog2(input int value);
        int res;
        res = 0;
        while ((1 << res) < value) begin
            res = res + 1;
        end
        return res;
    endfunction

    function automatic op_t decode_funct(input logic [5:0] funct);
        op_t op;
        op = OP_NONE;
        case (funct)
            FUNCT_MFHI:  op = OP_MFHI;
            FUNCT_MTHI:  op = OP_MTHI;
            FUNCT_MFLO:  op = OP_MFLO;
            FUNCT_MTLO:  op = OP_MTLO;
            FUNCT_MULT:  op = OP_MULT;
            FUNCT_MULTU: op = OP_MULTU;
            FUNCT_DIV:   op = OP_DIV;
            FUNCT_DIVU:  op = OP_DIVU;
            default:     op = OP_NONE;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/mips_muldiv_unit_core.sv
// Iterative radix-2 multiply / restoring-divide datapath with sign correction.
// Optional MULDIV_EARLY_TERM_EN lets a multiply finish once the remaining multiplier bits are zero.
module muldiv_core
    import mips_muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic             is_div_i,
    input  logic             is_signed_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             step_i,
    output logic             last_o,
    output logic [WIDTH-1:0] res_hi_o,
    output logic [WIDTH-1:0] res_lo_o,
    output logic             div_by_zero_o
);

    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               is_div_q, is_div_d;
    logic               hi_neg_q, hi_neg_d;
    logic               lo_neg_q, lo_neg_d;
    logic               dz_q, dz_d;

    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_nxt;
    logic [WIDTH:0]     rem_sh, rem_diff;
    logic               rem_ge;
    logic [2*WIDTH-1:0] div_nxt;
    logic [2*WIDTH-1:0] acc_neg;
    logic               early;

    assign a_neg = is_signed_i & a_i[WIDTH-1];
    assign b_neg = is_signed_i & b_i[WIDTH-1];
    assign mag_a = a_neg ? (~a_i + 1'b1) : a_i;
    assign mag_b = b_neg ? (~b_i + 1'b1) : b_i;

    // Multiply: low half holds the unconsumed multiplier, high half the running sum.
    assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});
    assign mul_nxt = {mul_sum, acc_q[WIDTH-1:1]};

    // Divide: high half is the partial remainder, low half shifts dividend out and quotient in.
    assign rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign rem_diff = rem_sh - {1'b0, opb_q};
    assign rem_ge   = (rem_sh >= {1'b0, opb_q});
    assign div_nxt  = rem_ge ? {rem_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1}
                             : {rem_sh[WIDTH-1:0],   acc_q[WIDTH-2:0], 1'b0};

`ifdef MULDIV_EARLY_TERM_EN
    logic [WIDTH-1:0] mpl_q, mpl_d;

    assign early = ~is_div_q & (mpl_q[WIDTH-1:1] == '0);

    always_comb begin
        mpl_d = mpl_q;
        if (load_i) begin
            mpl_d = mag_b;
        end else if (step_i) begin
            mpl_d = mpl_q >> 1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mpl_q <= '0;
        end else begin
            mpl_q <= mpl_d;
        end
    end
`else
    assign early = 1'b0;
`endif

    assign last_o = (cnt_q == CNT_W'(1)) | early;

    always_comb begin
        acc_d    = acc_q;
        opb_d    = opb_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        hi_neg_d = hi_neg_q;
        lo_neg_d = lo_neg_q;
        dz_d     = dz_q;
        if (load_i) begin
            cnt_d    = CNT_W'(WIDTH);
            is_div_d = is_div_i;
            if (is_div_i) begin
                acc_d    = {{WIDTH{1'b0}}, mag_a};
                opb_d    = mag_b;
                lo_neg_d = a_neg ^ b_neg;
                hi_neg_d = a_neg;
                dz_d     = (b_i == '0);
            end else begin
                acc_d    = {{WIDTH{1'b0}}, mag_b};
                opb_d    = mag_a;
                lo_neg_d = a_neg ^ b_neg;
                hi_neg_d = a_neg ^ b_neg;
                dz_d     = 1'b0;
            end
        end else if (step_i) begin
            cnt_d = cnt_q - CNT_W'(1);
            if (is_div_q) begin
                acc_d = div_nxt;
            end else if (last_o) begin
                // An early finish still owes (cnt_q-1) right shifts of the product.
                acc_d = mul_nxt >> (cnt_q - CNT_W'(1));
            end else begin
                acc_d = mul_nxt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q    <= '0;
            opb_q    <= '0;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            hi_neg_q <= 1'b0;
            lo_neg_q <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            opb_q    <= opb_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            hi_neg_q <= hi_neg_d;
            lo_neg_q <= lo_neg_d;
            dz_q     <= dz_d;
        end
    end

    assign acc_neg = ~acc_q + 1'b1;

    always_comb begin
        res_hi_o = acc_q[2*WIDTH-1:WIDTH];
        res_lo_o = acc_q[WIDTH-1:0];
        if (is_div_q) begin
            res_hi_o = hi_neg_q ? acc_neg[2*WIDTH-1:WIDTH] + ((acc_q[WIDTH-1:0] == '0) ? '0 : {WIDTH{1'b1}})
                                : acc_q[2*WIDTH-1:WIDTH];
            res_hi_o = hi_neg_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1) : acc_q[2*WIDTH-1:WIDTH];
            res_lo_o = dz_q ? {WIDTH{1'b1}}
                            : (lo_neg_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0]);
        end else if (lo_neg_q) begin
            res_hi_o = acc_neg[2*WIDTH-1:WIDTH];
            res_lo_o = acc_neg[WIDTH-1:0];
        end
    end

    assign div_by_zero_o = dz_q;

endmodule

// File: rtl/mips_muldiv_unit.sv
// MIPS HI/LO multiply/divide unit: funct decode, sequencing FSM, HI/LO registers, stall and MF read port.
// Build with MULDIV_EARLY_TERM_EN defined to let multiplies finish early on short multipliers.
module mips_muldiv_unit
    import mips_muldiv_pkg::*;
#(
    parameter int                    WIDTH     = 32,
    parameter int                    ALU_OP_W  = 3,
    parameter logic [ALU_OP_W-1:0]   R_TYPE_OP = 3'b111
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ALU_OP_W-1:0] alu_op_i,
    input  logic [5:0]          alu_function_i,
    input  logic                start_i,
    input  logic [WIDTH-1:0]    rs_data_i,
    input  logic [WIDTH-1:0]    rt_data_i,
    output logic                busy_o,
    output logic                stall_o,
    output logic                done_o,
    output logic [WIDTH-1:0]    hi_o,
    output logic [WIDTH-1:0]    lo_o,
    output logic [WIDTH-1:0]    mf_data_o,
    output logic                mf_valid_o,
    output logic                div_by_zero_o
);

    // state | meaning
    // IDLE  | waiting; accepts any HI/LO instruction
    // MUL   | one shift-add step per cycle
    // DIV   | one restoring-subtract step per cycle
    // FIX   | sign-corrected result written to HI/LO

    state_t           state_q, state_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] mf_data_q;
    logic             done_q, done_d;
    logic             dz_q, dz_d;

    op_t              op;
    logic             op_valid;
    logic             idle;
    logic             accept;
    logic             is_mul, is_div, is_md;
    logic             core_last;
    logic [WIDTH-1:0] core_hi, core_lo;
    logic             core_dz;

    assign op       = (alu_op_i == R_TYPE_OP) ? decode_funct(alu_function_i) : OP_NONE;
    assign op_valid = (op != OP_NONE);
    assign idle     = (state_q == IDLE);
    assign accept   = start_i & op_valid & idle & ~reset;
    assign is_mul   = (op == OP_MULT) | (op == OP_MULTU);
    assign is_div   = (op == OP_DIV)  | (op == OP_DIVU);
    assign is_md    = is_mul | is_div;

    assign busy_o  = ~idle;
    assign stall_o = start_i & op_valid & ~idle;

    muldiv_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk           (clk),
        .reset         (reset),
        .load_i        (accept & is_md),
        .is_div_i      (is_div),
        .is_signed_i   ((op == OP_MULT) | (op == OP_DIV)),
        .a_i           (rs_data_i),
        .b_i           (rt_data_i),
        .step_i        ((state_q == MUL) | (state_q == DIV)),
        .last_o        (core_last),
        .res_hi_o      (core_hi),
        .res_lo_o      (core_lo),
        .div_by_zero_o (core_dz)
    );

    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        dz_d    = dz_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (is_mul) state_d = MUL;
                    if (is_div) state_d = DIV;
                    if (is_md)  dz_d    = 1'b0;
                    if (op == OP_MTHI) hi_d = rs_data_i;
                    if (op == OP_MTLO) lo_d = rs_data_i;
                end
            end
            MUL, DIV: begin
                if (core_last) state_d = FIX;
            end
            FIX: begin
                state_d = IDLE;
                hi_d    = core_hi;
                lo_d    = core_lo;
                done_d  = 1'b1;
                dz_d    = core_dz;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            dz_q      <= 1'b0;
            mf_data_q <= '0;
        end else begin
            state_q   <= state_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
            dz_q      <= dz_d;
            mf_data_q <= mf_data_o;
        end
    end

    assign mf_valid_o    = accept & ((op == OP_MFHI) | (op == OP_MFLO));
    assign mf_data_o     = mf_valid_o ? ((op == OP_MFHI) ? hi_q : lo_q) : mf_data_q;
    assign hi_o          = hi_q;
    assign lo_o          = lo_q;
    assign done_o        = done_q;
    assign div_by_zero_o = dz_q;

endmodule

// File: doc/mips_muldiv_unit.md
Name: mips_muldiv_unit

Overview:
Parametrised iterative multiply/divide unit for the MIPS datapath. It extends ALU_Control-style function decoding from a purely combinational selector to a sequential HI/LO engine. Sits beside the ALU in EX and decodes R-type MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO from {alu_op_i, alu_function_i}. It owns the HI/LO registers and stalls the pipeline while an operation is in flight.

Parameters:
WIDTH, 32, operand and HI/LO width; must be even and at least 4.
ALU_OP_W, 3, width of alu_op_i.
R_TYPE_OP, 3'b111, alu_op_i value that marks an R-type instruction.

Ports:
clk  in  1  system clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
alu_op_i  in  ALU_OP_W  ALU op from main control
alu_function_i  in  6  instruction funct field
start_i  in  1  instruction valid in EX this cycle
rs_data_i  in  WIDTH  operand A (dividend/multiplicand; MTHI/MTLO source)
rt_data_i  in  WIDTH  operand B (divisor/multiplier)
busy_o  out  1  operation in flight
stall_o  out  1  hold the pipeline; this instruction is not accepted
done_o  out  1  one-cycle pulse when HI/LO are updated by mul/div
hi_o  out  WIDTH  HI register
lo_o  out  WIDTH  LO register
mf_data_o  out  WIDTH  MFHI/MFLO read data
mf_valid_o  out  1  mf_data_o valid this cycle
div_by_zero_o  out  1  last DIV/DIVU had a zero divisor; sticky until the next mul/div start

Behaviour:
- Decode only when alu_op_i==R_TYPE_OP. Funct codes: MFHI 0x10, MTHI 0x11, MFLO 0x12, MTLO 0x13, MULT 0x18, MULTU 0x19, DIV 0x1A, DIVU 0x1B. Any other funct is ignored and produces no stall.
- Reset: state IDLE, hi_o=lo_o=0, busy_o=done_o=div_by_zero_o=mf_valid_o=0, mf_data_o=0. Reset mid-operation aborts the operation; the cycle after reset, busy_o=0.
- FSM states: IDLE, MUL, DIV, FIX.
  - IDLE: start_i plus MULT/MULTU moves to MUL; start_i plus DIV/DIVU moves to DIV. Operands are latched as magnitudes and result signs are recorded (signed ops only). The iteration counter is loaded with WIDTH.
  - MUL/DIV: radix-2, one shift-add or restoring subtract step per cycle, counter decrements, moves to FIX when the counter reaches 1.
  - FIX: apply sign correction and write HI/LO; done_o=1 for this edge's following cycle; return to IDLE.
- Latency: start accepted at edge E0. busy_o is high from after E0 through after E_WIDTH, i.e. exactly WIDTH+1 cycles. HI/LO take new values after edge E_{WIDTH+1}, coincident with the done_o pulse.
- MULT/MULTU: {HI,LO} = full 2*WIDTH-bit product, signed or unsigned respectively.
- DIV/DIVU: LO=quotient truncated toward zero; HI=remainder, taking the sign of the dividend.
- Divisor 0: LO=all ones, HI=dividend, div_by_zero_o=1. Latency is the same as a normal divide.
- Signed overflow (MIN / -1): LO=MIN, HI=0, no flag.
- stall_o is combinational: start_i & decoded-any-HI/LO-op & (busy_o | state!=IDLE). A stalled instruction has no side effect and is not latched. It is re-presented by the pipeline and accepted the cycle busy_o falls.
- MFHI/MFLO when idle: mf_data_o = hi_o or lo_o combinationally, mf_valid_o=1 the same cycle. Otherwise mf_valid_o=0 and mf_data_o holds its last value.
- MTHI/MTLO when idle: write rs_data_i to HI/LO at the edge; visible the next cycle.
- Simultaneous FIX write and a stalled MT*: the MT* is accepted the following cycle, so the MT* write wins.

Optional Feature:
Macro MULDIV_EARLY_TERM_EN.
- Defined: in MUL, when the remaining unshifted multiplier bits are all zero, jump to FIX with the partial product shifted into final position. Minimum busy is 2 cycles (one MUL cycle plus FIX); busy never exceeds WIDTH+1. DIV is unchanged.
- Undefined: fixed WIDTH+1 busy latency for every operation.

Decomposition:
- Package mips_muldiv_pkg holds:
  - funct localparams;
  - state enum {IDLE, MUL, DIV, FIX};
  - op enum {OP_NONE, OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MFHI, OP_MFLO, OP_MTHI, OP_MTLO};
  - counter width function clog2(WIDTH+1).
- Sub-module muldiv_core contains the iterative datapath: accumulator, shift registers, counter and sign fix. The top level keeps decode, the FSM, HI/LO, stall and MF logic.

Test Plan (WIDTH=32):
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> busy_o high exactly 33 cycles; then HI=0xFFFFFFFE, LO=0x00000001, done_o pulses once.
- MULT 0xFFFFFFFD (-3) x 7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- DIV 0xFFFFFFF9 (-7) / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU 5 / 0 -> LO=0xFFFFFFFF, HI=0x00000005, div_by_zero_o=1. A following MULTU 2 x 3 clears it and gives LO=6.
- MFLO presented every cycle starting 1 cycle after MULT start -> stall_o=1 for 33 cycles; the first unstalled cycle gives mf_valid_o=1 and mf_data_o = new LO. MTHI 0x1234 when idle -> hi_o=0x1234 the next cycle.
- Reset asserted 10 cycles into DIV -> next cycle busy_o=0, hi_o=lo_o=0, and no done_o pulse. With MULDIV_EARLY_TERM_EN defined, MULTU 9 x 1 -> busy_o high 2 cycles, LO=9.
